// File: rtl/fifo_wr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wr_pkg : shared types and constants for the FIFO write arbiter|
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package fifo_wr_pkg;

   localparam int unsigned FIFO_DATA_WIDTH = 8;

   localparam int unsigned REQ_IDX_A = 0;
   localparam int unsigned REQ_IDX_B = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2,
      SEND_B  = 2'd3
   } wr_state_e;

endpackage : fifo_wr_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arb2  : two-input arbiter with one-hot grant output             |
// |            FIFO_WR_ROUND_ROBIN_EN selects round robin, else fixed  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module rr_arb2
   import fifo_wr_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

`ifdef FIFO_WR_ROUND_ROBIN_EN
   // Pointer holds 1 when B was granted last; reset value lets A win first.
   logic last_b_q;
   logic last_b_d;

   always_comb begin
      gnt      = 2'b00;
      last_b_d = last_b_q;
      if (req[REQ_IDX_A] && (!req[REQ_IDX_B] || last_b_q)) begin
         gnt[REQ_IDX_A] = 1'b1;
      end else if (req[REQ_IDX_B]) begin
         gnt[REQ_IDX_B] = 1'b1;
      end
      if (|gnt) begin
         last_b_d = gnt[REQ_IDX_B];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_d;
      end
   end
`else
   logic w_unused;

   always_comb begin
      gnt            = 2'b00;
      gnt[REQ_IDX_A] = req[REQ_IDX_A];
      gnt[REQ_IDX_B] = req[REQ_IDX_B] & ~req[REQ_IDX_A];
   end

   // Fixed priority is stateless; clock and reset are kept for a uniform port list.
   assign w_unused = &{1'b0, clk, rst_n};
`endif

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wr_arbiter : shares the FIFO write port between a 2-byte and  |
// |                   a 1-byte requester, serialising bytes on !full   |
// |                   Option: FIFO_WR_ROUND_ROBIN_EN (tie arbitration) |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module fifo_wr_arbiter
   import fifo_wr_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_a,
   input  logic [2*DATA_WIDTH-1:0] data_a,
   input  logic                    req_b,
   input  logic [DATA_WIDTH-1:0]   data_b,
   input  logic                    wr_full,
   output logic                    gnt_a,
   output logic                    gnt_b,
   output logic                    wr_inc,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic                    busy
);

   wr_state_e               state_q;
   wr_state_e               state_d;
   logic [2*DATA_WIDTH-1:0] hold_q;
   logic [2*DATA_WIDTH-1:0] hold_d;
   logic [1:0]              w_arb_req;
   logic [1:0]              w_gnt;

   // Requests only reach the arbiter in IDLE, so grants and pointer updates
   // cannot happen mid-transfer.
   always_comb begin
      w_arb_req            = 2'b00;
      w_arb_req[REQ_IDX_A] = req_a && (state_q == IDLE);
      w_arb_req[REQ_IDX_B] = req_b && (state_q == IDLE);
   end

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (w_arb_req),
      .gnt   (w_gnt)
   );

   assign gnt_a = w_gnt[REQ_IDX_A];
   assign gnt_b = w_gnt[REQ_IDX_B];
   assign busy  = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      wr_inc  = 1'b0;
      wr_data = '0;
      case (state_q)
         IDLE: begin
            if (gnt_a) begin
               hold_d  = data_a;
               state_d = SEND_LO;
            end else if (gnt_b) begin
               hold_d  = {{DATA_WIDTH{1'b0}}, data_b};
               state_d = SEND_B;
            end
         end
         SEND_LO: begin
            wr_data = hold_q[DATA_WIDTH-1:0];
            if (!wr_full) begin
               wr_inc  = 1'b1;
               state_d = SEND_HI;
            end
         end
         SEND_HI: begin
            wr_data = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
            if (!wr_full) begin
               wr_inc  = 1'b1;
               state_d = IDLE;
            end
         end
         SEND_B: begin
            wr_data = hold_q[DATA_WIDTH-1:0];
            if (!wr_full) begin
               wr_inc  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_wr_arbiter : directed vector bench for fifo_wr_arbiter     |
// | Revision           : 1.0                                           |
// +--------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam int   NV = 26;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_a;
   logic [15:0] data_a;
   logic        req_b;
   logic [7:0]  data_b;
   logic        wr_full;
   logic        gnt_a;
   logic        gnt_b;
   logic        wr_inc;
   logic [7:0]  wr_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ra;
      logic [15:0] da;
      logic        rb;
      logic [7:0]  db;
      logic        full;
      logic        e_ga;
      logic        e_gb;
      logic        e_inc;
      logic [7:0]  e_wd;
      logic        e_busy;
   } vec_t;

   vec_t vecs [NV];

   always #5 clk = ~clk;

   fifo_wr_arbiter dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a   (req_a),
      .data_a  (data_a),
      .req_b   (req_b),
      .data_b  (data_b),
      .wr_full (wr_full),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b),
      .wr_inc  (wr_inc),
      .wr_data (wr_data),
      .busy    (busy)
   );

   function automatic vec_t mk(input logic ra, input logic [15:0] da, input logic rb,
                               input logic [7:0] db, input logic full, input logic ga,
                               input logic gb, input logic inc, input logic [7:0] wd,
                               input logic bz);
      vec_t v;
      v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.full = full;
      v.e_ga = ga; v.e_gb = gb; v.e_inc = inc; v.e_wd = wd; v.e_busy = bz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic ga, input logic gb, input logic inc,
                          input logic [7:0] wd, input logic bz);
      chk({tag, ".gnt_a"},   {15'd0, gnt_a},  {15'd0, ga});
      chk({tag, ".gnt_b"},   {15'd0, gnt_b},  {15'd0, gb});
      chk({tag, ".wr_inc"},  {15'd0, wr_inc}, {15'd0, inc});
      chk({tag, ".wr_data"}, {8'd0, wr_data}, {8'd0, wd});
      chk({tag, ".busy"},    {15'd0, busy},   {15'd0, bz});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_a = 1'b0; data_a = 16'h0000; req_b = 1'b0; data_b = 8'h00; wr_full = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   logic [1:0] exp_order [4];
   logic [1:0] got_order [4];
   int         n_gnt;

   initial begin
      // Single-requester vectors, one row per cycle starting in IDLE.
      vecs[0]  = mk(H, 16'hBEEF, L, 8'h00, L,  H, L, L, 8'h00, L);
      vecs[1]  = mk(L, 16'h0000, L, 8'h00, L,  L, L, H, 8'hEF, H);
      vecs[2]  = mk(L, 16'h0000, L, 8'h00, L,  L, L, H, 8'hBE, H);
      vecs[3]  = mk(L, 16'h0000, L, 8'h00, L,  L, L, L, 8'h00, L);
      vecs[4]  = mk(L, 16'h0000, H, 8'h5A, L,  L, H, L, 8'h00, L);
      vecs[5]  = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h5A, H);
      vecs[6]  = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h5A, H);
      vecs[7]  = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h5A, H);
      vecs[8]  = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h5A, H);
      vecs[9]  = mk(L, 16'h0000, L, 8'h00, L,  L, L, H, 8'h5A, H);
      vecs[10] = mk(L, 16'h0000, L, 8'h00, L,  L, L, L, 8'h00, L);
      vecs[11] = mk(H, 16'h1234, L, 8'h00, L,  H, L, L, 8'h00, L);
      vecs[12] = mk(L, 16'h0000, L, 8'h00, L,  L, L, H, 8'h34, H);
      vecs[13] = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h12, H);
      vecs[14] = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h12, H);
      vecs[15] = mk(L, 16'h0000, L, 8'h00, L,  L, L, H, 8'h12, H);
      vecs[16] = mk(L, 16'h0000, L, 8'h00, L,  L, L, L, 8'h00, L);
      vecs[17] = mk(H, 16'hC3A5, L, 8'h00, L,  H, L, L, 8'h00, L);
      vecs[18] = mk(L, 16'h0000, H, 8'h77, L,  L, L, H, 8'hA5, H);
      vecs[19] = mk(L, 16'h0000, L, 8'h00, L,  L, L, H, 8'hC3, H);
      vecs[20] = mk(L, 16'h0000, L, 8'h00, L,  L, L, L, 8'h00, L);
      vecs[21] = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h00, L);
      vecs[22] = mk(L, 16'h0000, H, 8'h77, H,  L, H, L, 8'h00, L);
      vecs[23] = mk(L, 16'h0000, L, 8'h00, H,  L, L, L, 8'h77, H);
      vecs[24] = mk(L, 16'h0000, L, 8'h00, L,  L, L, H, 8'h77, H);
      vecs[25] = mk(L, 16'h0000, L, 8'h00, L,  L, L, L, 8'h00, L);

      rst_n = 1'b0;
      idle_inputs();
      cyc();
      @(negedge clk);
      chk_out("reset", L, L, L, 8'h00, L);
      cyc();
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         req_a = vecs[i].ra; data_a = vecs[i].da;
         req_b = vecs[i].rb; data_b = vecs[i].db;
         wr_full = vecs[i].full;
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), vecs[i].e_ga, vecs[i].e_gb, vecs[i].e_inc,
                 vecs[i].e_wd, vecs[i].e_busy);
         cyc();
      end

      // Both requesters held continuously from a fresh reset.
`ifdef FIFO_WR_ROUND_ROBIN_EN
      exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
`else
      exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01; exp_order[3] = 2'b01;
`endif
      do_reset();
      req_a = 1'b1; data_a = 16'hA1A2; req_b = 1'b1; data_b = 8'hB5; wr_full = 1'b0;
      n_gnt = 0;
      for (int c = 0; c < 20 && n_gnt < 4; c++) begin
         @(negedge clk);
         if (gnt_a || gnt_b) begin
            got_order[n_gnt] = {gnt_b, gnt_a};
            n_gnt++;
         end
         cyc();
      end
      chk("tie.grant_count", n_gnt[15:0], 16'd4);
      for (int k = 0; k < n_gnt; k++) begin
         chk($sformatf("tie.grant%0d", k), {14'd0, got_order[k]}, {14'd0, exp_order[k]});
      end
      idle_inputs();

      // Reset while stalled in SEND_HI, then B served in first IDLE cycle.
      do_reset();
      req_a = 1'b1; data_a = 16'h9E3C;
      @(negedge clk);
      chk_out("rst.grant", H, L, L, 8'h00, L);
      cyc();
      req_a = 1'b0; data_a = 16'h0000;
      @(negedge clk);
      chk_out("rst.lo", L, L, H, 8'h3C, H);
      cyc();
      wr_full = 1'b1;
      @(negedge clk);
      chk_out("rst.hi_stall", L, L, L, 8'h9E, H);
      rst_n = 1'b0;
      #1;
      chk_out("rst.async", L, L, L, 8'h00, L);
      cyc();
      @(negedge clk);
      chk_out("rst.held", L, L, L, 8'h00, L);
      cyc();
      rst_n = 1'b1; wr_full = 1'b0; req_b = 1'b1; data_b = 8'h6D;
      @(negedge clk);
      chk_out("rst.gnt_b", L, H, L, 8'h00, L);
      cyc();
      req_b = 1'b0; data_b = 8'h00;
      @(negedge clk);
      chk_out("rst.b_write", L, L, H, 8'h6D, H);
      cyc();
      @(negedge clk);
      chk_out("rst.done", L, L, L, 8'h00, L);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
